// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU internal-operation sequencer and the Ctrl decoder benches:
// op codes, FSM states, step codes and the four-bit active-low step encodings.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_ADDR = 3'd4;
  localparam logic [2:0] OP_PUSH = 3'd5;
  localparam logic [2:0] OP_POP  = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP1 = 2'd1,
    ST_STEP2 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    STEP_NORMAL = 3'd0,
    STEP_MOV    = 3'd1,
    STEP_INC    = 3'd2,
    STEP_DEC    = 3'd3,
    STEP_ADDR   = 3'd4
  } step_e;

  // Bit order {mov_n, addr_n, incdec_n, dec_n}.
  localparam logic [3:0] ENC_NORMAL = 4'b1111;
  localparam logic [3:0] ENC_MOV    = 4'b0111;
  localparam logic [3:0] ENC_INC    = 4'b0101;
  localparam logic [3:0] ENC_DEC    = 4'b0100;
  localparam logic [3:0] ENC_ADDR   = 4'b0011;

  function automatic step_e first_step(input logic [2:0] op);
    step_e s;
    s = STEP_NORMAL;
    unique case (op)
      OP_MOV:  s = STEP_MOV;
      OP_INC:  s = STEP_INC;
      OP_DEC:  s = STEP_DEC;
      OP_ADDR: s = STEP_ADDR;
      OP_PUSH: s = STEP_DEC;
      OP_POP:  s = STEP_MOV;
      default: s = STEP_NORMAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_internal_seq_if.sv
// Request/mode bus between the instruction control unit (master) and the
// internal-operation sequencer (slave).
interface alu_internal_seq_if #(
  parameter int OP_W  = 3,
  parameter int REP_W = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [OP_W-1:0]  op;
  logic [REP_W-1:0] rep;
  logic             stall;
  logic             abort;
  logic             internal_mov_n;
  logic             address_mode_n;
  logic             internal_inc_dec_n;
  logic             internal_dec_n;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start_valid, op, rep, stall, abort,
    input  start_ready, internal_mov_n, address_mode_n, internal_inc_dec_n,
           internal_dec_n, busy, done, err
  );

  modport slave (
    input  start_valid, op, rep, stall, abort,
    output start_ready, internal_mov_n, address_mode_n, internal_inc_dec_n,
           internal_dec_n, busy, done, err
  );
endinterface

// File: rtl/alu_step_enc.sv
// Combinational map from a step code to the four active-low mode lines,
// in {mov_n, addr_n, incdec_n, dec_n} order.
module alu_step_enc
  import alu_ctrl_pkg::*;
(
  input  step_e      step,
  output logic [3:0] enc_n
);

  always_comb begin
    enc_n = ENC_NORMAL;
    unique case (step)
      STEP_MOV:  enc_n = ENC_MOV;
      STEP_INC:  enc_n = ENC_INC;
      STEP_DEC:  enc_n = ENC_DEC;
      STEP_ADDR: enc_n = ENC_ADDR;
      default:   enc_n = ENC_NORMAL;
    endcase
  end

endmodule

// File: rtl/alu_internal_seq.sv
// Internal-operation micro-sequencer feeding the ALU Ctrl decoders with
// registered active-low mode lines and a one-cycle done/err pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a request; start_ready high unless stalled
// ST_STEP1 | first step of the op; INC/DEC repeat here while cnt != 0
// ST_STEP2 | second step for ADDR, PUSH and POP
// ST_DONE  | done (and err for reserved op) asserted, mode lines normal
module alu_internal_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W  = 3,
  parameter int REP_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_internal_seq_if.slave bus
);

  state_e           state_q, state_d;
  step_e            step_q, step_d;
  logic [REP_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [3:0]       out_n_q, out_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;

  assign bus.start_ready = (state_q == ST_IDLE) && !bus.stall;
  assign accept          = bus.start_valid && bus.start_ready && !bus.abort;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
      step_d  = STEP_NORMAL;
      cnt_d   = '0;
    end else if (!bus.stall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d  = bus.op;
            cnt_d = bus.rep;
            if (bus.op == OP_NOP || bus.op == OP_RSV) begin
              state_d = ST_DONE;
              step_d  = STEP_NORMAL;
            end else begin
              state_d = ST_STEP1;
              step_d  = first_step(bus.op);
            end
          end
        end
        ST_STEP1: begin
          unique case (op_q)
            // Exit test is on the pre-decrement value, so rep=max never wraps.
            OP_INC, OP_DEC: begin
              if (cnt_q != '0) begin
                cnt_d = cnt_q - REP_W'(1);
              end else begin
                state_d = ST_DONE;
                step_d  = STEP_NORMAL;
              end
            end
            OP_ADDR, OP_PUSH: begin
              state_d = ST_STEP2;
              step_d  = STEP_MOV;
            end
            OP_POP: begin
              state_d = ST_STEP2;
              step_d  = STEP_INC;
            end
            default: begin
              state_d = ST_DONE;
              step_d  = STEP_NORMAL;
            end
          endcase
        end
        ST_STEP2: begin
          state_d = ST_DONE;
          step_d  = STEP_NORMAL;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          step_d  = STEP_NORMAL;
        end
        default: begin
          state_d = ST_IDLE;
          step_d  = STEP_NORMAL;
        end
      endcase
    end
  end

  // Flags follow the next state, so a stalled DONE keeps done high.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    err_d  = done_d && (op_d == OP_RSV);
  end

  alu_step_enc u_step_enc (
    .step  (step_d),
    .enc_n (out_n_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_NORMAL;
      cnt_q   <= '0;
      op_q    <= '0;
      out_n_q <= ENC_NORMAL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      out_n_q <= out_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign {bus.internal_mov_n, bus.address_mode_n,
          bus.internal_inc_dec_n, bus.internal_dec_n} = out_n_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_alu_internal_seq.sv
// Bench for alu_internal_seq: a queue-of-steps reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_internal_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_internal_seq_if #(.OP_W(3), .REP_W(4)) bus ();

  alu_internal_seq #(.OP_W(3), .REP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] M_NORM = 4'b1111;
  localparam logic [3:0] M_MOV  = 4'b0111;
  localparam logic [3:0] M_INC  = 4'b0101;
  localparam logic [3:0] M_DEC  = 4'b0100;
  localparam logic [3:0] M_ADDR = 4'b0011;

  typedef struct {
    logic [3:0] mode;
    bit         done;
    bit         err;
    bit         busy;
  } item_t;

  item_t mcur;
  item_t mq[$];

  function automatic item_t mk(logic [3:0] m, bit d, bit e, bit b);
    item_t it;
    it.mode = m;
    it.done = d;
    it.err  = e;
    it.busy = b;
    return it;
  endfunction

  // Whole visible sequence of one request, first step up to and including the DONE cycle.
  function automatic void build(int op, int rep);
    case (op)
      1: mq.push_back(mk(M_MOV, 0, 0, 1));
      2: for (int i = 0; i <= rep; i++) mq.push_back(mk(M_INC, 0, 0, 1));
      3: for (int i = 0; i <= rep; i++) mq.push_back(mk(M_DEC, 0, 0, 1));
      4: begin mq.push_back(mk(M_ADDR, 0, 0, 1)); mq.push_back(mk(M_MOV, 0, 0, 1)); end
      5: begin mq.push_back(mk(M_DEC, 0, 0, 1));  mq.push_back(mk(M_MOV, 0, 0, 1)); end
      6: begin mq.push_back(mk(M_MOV, 0, 0, 1));  mq.push_back(mk(M_INC, 0, 0, 1)); end
      default: ;
    endcase
    mq.push_back(mk(M_NORM, 1, (op == 7), 1));
  endfunction

  initial begin
    mcur = mk(M_NORM, 0, 0, 0);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || bus.abort) begin
        mq.delete();
        mcur = mk(M_NORM, 0, 0, 0);
      end else if (bus.stall) begin
        mcur = mcur;
      end else if (mq.size() > 0) begin
        mcur = mq.pop_front();
      end else if (!mcur.busy && bus.start_valid) begin
        build(int'(bus.op), int'(bus.rep));
        mcur = mq.pop_front();
      end else begin
        mcur = mk(M_NORM, 0, 0, 0);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mode_act();
    return {bus.internal_mov_n, bus.address_mode_n, bus.internal_inc_dec_n, bus.internal_dec_n};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      chk("model_mode", mode_act(), mcur.mode);
      chk("model_done", bus.done, mcur.done);
      chk("model_err", bus.err, mcur.err);
      chk("model_busy", bus.busy, mcur.busy);
      chk("model_ready", bus.start_ready, !mcur.busy && !bus.stall);
    end
  end

  task automatic lit(string name, logic [3:0] m, bit d, bit e, bit b);
    chk({name, "_mode"}, mode_act(), m);
    chk({name, "_done"}, bus.done, d);
    chk({name, "_err"}, bus.err, e);
    chk({name, "_busy"}, bus.busy, b);
  endtask

  task automatic drive(bit sv, int op, int rep, bit st, bit ab);
    bus.start_valid = sv;
    bus.op          = 3'(op);
    bus.rep         = 4'(rep);
    bus.stall       = st;
    bus.abort       = ab;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Async reset in the middle of an INC run
    drive(1, 2, 5, 0, 0); tick(); drive(0, 0, 0, 0, 0); tick();
    lit("pre_rst", M_INC, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    lit("rst_async", M_NORM, 0, 0, 0);
    chk("rst_ready", bus.start_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_no_done", bus.done, 0);
    end

    // INC rep=3: four INC cycles, done at T+5, ready at T+6
    drive(1, 2, 3, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      lit("inc_step", M_INC, 0, 0, 1);
      tick();
    end
    lit("inc_done", M_NORM, 1, 0, 1);
    chk("inc_done_ready", bus.start_ready, 0);
    tick();
    lit("inc_idle", M_NORM, 0, 0, 0);
    chk("inc_idle_ready", bus.start_ready, 1);

    // PUSH then ADDR
    drive(1, 5, 9, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    lit("push_dec", M_DEC, 0, 0, 1); tick();
    lit("push_mov", M_MOV, 0, 0, 1); tick();
    lit("push_done", M_NORM, 1, 0, 1); tick();
    drive(1, 4, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    lit("addr_addr", M_ADDR, 0, 0, 1); tick();
    lit("addr_mov", M_MOV, 0, 0, 1); tick();
    lit("addr_done", M_NORM, 1, 0, 1); tick();

    // DEC rep=2 with the 2nd DEC cycle stalled for three cycles
    drive(1, 3, 2, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    lit("dec_1", M_DEC, 0, 0, 1); tick();
    lit("dec_2", M_DEC, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("dec_stall", M_DEC, 0, 0, 1);
    end
    drive(0, 0, 0, 0, 0);
    tick(); lit("dec_last", M_DEC, 0, 0, 1);
    tick(); lit("dec_done", M_NORM, 1, 0, 1);
    tick();

    // Stall in IDLE blocks accept
    drive(1, 1, 0, 1, 0);
    #1;
    chk("stall_idle_ready", bus.start_ready, 0);
    tick(); drive(0, 0, 0, 0, 0);
    lit("stall_idle_noacc", M_NORM, 0, 0, 0);

    // POP aborted in STEP2, then abort together with a request in IDLE
    drive(1, 6, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    lit("pop_mov", M_MOV, 0, 0, 1); tick();
    lit("pop_inc", M_INC, 0, 0, 1);
    drive(0, 0, 0, 0, 1); tick();
    lit("pop_abort", M_NORM, 0, 0, 0);
    drive(1, 1, 0, 0, 1); tick(); drive(0, 0, 0, 0, 0);
    lit("abort_sv_idle", M_NORM, 0, 0, 0);
    tick();
    chk("abort_sv_no_done", bus.done, 0);

    // Reserved op and NOP
    drive(1, 7, 3, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    lit("rsv_done", M_NORM, 1, 1, 1); tick();
    lit("rsv_idle", M_NORM, 0, 0, 0);
    drive(1, 0, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    lit("nop_done", M_NORM, 1, 0, 1); tick();
    lit("nop_idle", M_NORM, 0, 0, 0);

    // Maximum repeat count: 16 INC cycles, no wrap
    drive(1, 2, 15, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      lit("incmax_step", M_INC, 0, 0, 1);
      tick();
    end
    lit("incmax_done", M_NORM, 1, 0, 1);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15),
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4);
      tick();
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
